// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: datapath width, FSM state encodings
// and the writeback result selector.
package mem_stage_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  function automatic logic [DATA_W-1:0] wb_select(
    input logic              mem_to_reg,
    input logic [DATA_W-1:0] rdata,
    input logic [DATA_W-1:0] alu_result
  );
    return mem_to_reg ? rdata : alu_result;
  endfunction

endpackage

// File: rtl/mem_stage_ex_mem_reg.sv
// EX/MEM pipeline register: loads when enabled, holds while the stage stalls,
// and can drop its valid bit once a held memory op has completed.
module ex_mem_reg
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              ex_valid,
  input  logic              ex_flush,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [2:0]        ex_write_reg_addr,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_alu_result,
  output logic [DATA_W-1:0] m_store_data,
  output logic [2:0]        m_write_reg_addr,
  output logic              m_reg_write,
  output logic              m_mem_read,
  output logic              m_mem_write,
  output logic              m_mem_to_reg
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid          <= 1'b0;
      m_alu_result     <= '0;
      m_store_data     <= '0;
      m_write_reg_addr <= '0;
      m_reg_write      <= 1'b0;
      m_mem_read       <= 1'b0;
      m_mem_write      <= 1'b0;
      m_mem_to_reg     <= 1'b0;
    end else if (en) begin
      m_valid          <= ex_valid && !ex_flush;
      m_alu_result     <= ex_alu_result;
      m_store_data     <= ex_store_data;
      m_write_reg_addr <= ex_write_reg_addr;
      m_reg_write      <= ex_reg_write;
      m_mem_read       <= ex_mem_read;
      m_mem_write      <= ex_mem_write;
      m_mem_to_reg     <= ex_mem_to_reg;
    end else if (clr) begin
      // A held op that just retired must not be issued a second time.
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, data-memory req/ready access FSM with timeout,
// MEM/WB register and the MEM-stage forwarding taps back to EX.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_flush,
  input  logic [15:0]       ex_alu_result,
  input  logic [15:0]       ex_store_data,
  input  logic [2:0]        ex_write_reg_addr,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic [15:0]       dmem_rdata,
  input  logic              dmem_ready,
  output logic              mem_stall,
  output logic [15:0]       mem_forward_data,
  output logic [2:0]        mem_fwd_reg_addr,
  output logic              mem_fwd_reg_write,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [2:0]        wb_reg_addr,
  output logic [15:0]       wb_data,
  output logic              bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic              m_valid;
  logic [DATA_W-1:0] m_alu_result;
  logic [DATA_W-1:0] m_store_data;
  logic [2:0]        m_write_reg_addr;
  logic              m_reg_write;
  logic              m_mem_read;
  logic              m_mem_write;
  logic              m_mem_to_reg;

  mem_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              is_mem;
  logic              retire;
  logic              timeout;
  logic              hold_clr;
  logic              load_en;

  assign load_en = !mem_stall;

  ex_mem_reg u_ex_mem_reg (
    .clk               (clk),
    .rst_n             (rst_n),
    .en                (load_en),
    .clr               (hold_clr),
    .ex_valid          (ex_valid),
    .ex_flush          (ex_flush),
    .ex_alu_result     (ex_alu_result),
    .ex_store_data     (ex_store_data),
    .ex_write_reg_addr (ex_write_reg_addr),
    .ex_reg_write      (ex_reg_write),
    .ex_mem_read       (ex_mem_read),
    .ex_mem_write      (ex_mem_write),
    .ex_mem_to_reg     (ex_mem_to_reg),
    .m_valid           (m_valid),
    .m_alu_result      (m_alu_result),
    .m_store_data      (m_store_data),
    .m_write_reg_addr  (m_write_reg_addr),
    .m_reg_write       (m_reg_write),
    .m_mem_read        (m_mem_read),
    .m_mem_write       (m_mem_write),
    .m_mem_to_reg      (m_mem_to_reg)
  );

  assign is_mem     = m_valid && (m_mem_read || m_mem_write);
  assign dmem_we    = dmem_req && m_mem_write;
  assign dmem_addr  = m_alu_result[ADDR_W-1:0];
  assign dmem_wdata = m_store_data;

  assign mem_forward_data  = m_alu_result;
  assign mem_fwd_reg_addr  = m_write_reg_addr;
  assign mem_fwd_reg_write = m_valid && m_reg_write;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dmem_req   = 1'b0;
    mem_stall  = 1'b0;
    retire     = 1'b0;
    timeout    = 1'b0;
    hold_clr   = 1'b0;
    case (state)
      MEM_IDLE: begin
        dmem_req = is_mem;
        if (is_mem) begin
          if (dmem_ready) begin
            retire = 1'b1;
          end else begin
            mem_stall  = 1'b1;
            state_next = MEM_WAIT;
            cnt_next   = CNT_W'(1);
          end
        end else if (m_valid) begin
          retire = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        if (dmem_ready) begin
          retire     = 1'b1;
          hold_clr   = 1'b1;
          state_next = MEM_IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          retire     = 1'b1;
          timeout    = 1'b1;
          hold_clr   = 1'b1;
          state_next = MEM_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  // MEM/WB boundary: bubbles clear valid/write-enable but keep data and address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= MEM_IDLE;
      cnt          <= '0;
      bus_error    <= 1'b0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_reg_addr  <= '0;
      wb_data      <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      wb_valid     <= retire;
      wb_reg_write <= retire && m_reg_write && !timeout;
      if (timeout) begin
        bus_error <= 1'b1;
      end
      if (retire) begin
        wb_reg_addr <= m_write_reg_addr;
        wb_data     <= wb_select(m_mem_to_reg, dmem_rdata, m_alu_result);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: reset, table of ALU pass-through vectors, directed
// memory corner cases, then random traffic against a transaction-level model.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_flush;
  logic [15:0] ex_alu_result, ex_store_data;
  logic [2:0]  ex_write_reg_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        mem_stall;
  logic [15:0] mem_forward_data;
  logic [2:0]  mem_fwd_reg_addr;
  logic        mem_fwd_reg_write;
  logic        wb_valid, wb_reg_write;
  logic [2:0]  wb_reg_addr;
  logic [15:0] wb_data;
  logic        bus_error;

  mem_stage #(.ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_write_reg_addr(ex_write_reg_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_stall(mem_stall), .mem_forward_data(mem_forward_data),
    .mem_fwd_reg_addr(mem_fwd_reg_addr), .mem_fwd_reg_write(mem_fwd_reg_write),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_reg_addr(wb_reg_addr), .wb_data(wb_data), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic f, input logic [15:0] alu,
                        input logic [15:0] sd, input logic [2:0] rd, input logic rw,
                        input logic mr, input logic mw, input logic m2r);
    ex_valid = v; ex_flush = f; ex_alu_result = alu; ex_store_data = sd;
    ex_write_reg_addr = rd; ex_reg_write = rw; ex_mem_read = mr;
    ex_mem_write = mw; ex_mem_to_reg = m2r;
  endtask

  task automatic ex_idle();
    ex_set(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        v, f;
    logic [15:0] alu;
    logic [2:0]  rd;
    logic        rw;
    logic        e_fwrw;
    logic        e_wbv, e_wbrw;
    logic [2:0]  e_wba;
    logic [15:0] e_wbd;
  } vec_t;

  typedef struct {
    logic [15:0] alu, sd;
    logic [2:0]  rd;
    logic        rw, mr, mw, m2r;
  } op_t;

  // Random-phase state: pending EX instruction, in-order model, memory images.
  op_t         q[$];
  logic [15:0] model_mem[16];
  logic [15:0] env_mem[16];
  logic        p_v, p_f, p_rw, p_mr, p_mw, p_m2r;
  logic [15:0] p_alu, p_sd;
  logic [2:0]  p_rd;
  bit          gen_on;
  bit          in_acc;
  bit          front_to;
  bit          exp_bus_err;
  int          waited, lat;

  task automatic new_pending();
    int kind;
    kind  = $urandom_range(0, 8);
    p_v   = gen_on && ($urandom_range(0, 9) != 0);
    p_f   = ($urandom_range(0, 7) == 0);
    p_rd  = 3'($urandom_range(0, 7));
    p_rw  = 1'($urandom_range(0, 1));
    p_sd  = 16'($urandom);
    p_mr  = (kind >= 3 && kind <= 5) || kind == 8;
    p_mw  = kind >= 6;
    p_m2r = (kind >= 3 && kind <= 5) && ($urandom_range(0, 3) != 0);
    p_alu = (p_mr || p_mw) ? 16'($urandom_range(0, 15)) : 16'($urandom);
  endtask

  task automatic rand_cycle();
    op_t         e;
    logic [15:0] exp_d;
    logic        rdy;
    if (wb_valid) begin
      if (q.size() == 0) begin
        chk("rand_spurious_retire", 1, 0);
      end else begin
        e = q.pop_front();
        chk("rand_wb_reg_write", wb_reg_write, e.rw && !front_to);
        chk("rand_wb_reg_addr", wb_reg_addr, e.rd);
        if (!front_to) begin
          exp_d = e.m2r ? model_mem[e.alu[3:0]] : e.alu;
          chk("rand_wb_data", wb_data, exp_d);
          if (e.mw) model_mem[e.alu[3:0]] = e.sd;
        end
        front_to = 1'b0;
      end
    end else begin
      chk("rand_bubble_reg_write", wb_reg_write, 0);
    end
    chk("rand_bus_error", bus_error, exp_bus_err);
    ex_set(p_v, p_f, p_alu, p_sd, p_rd, p_rw, p_mr, p_mw, p_m2r);
    dmem_ready = 1'b0;
    dmem_rdata = 16'($urandom);
    #1;
    if (dmem_req) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        waited = 0;
        lat = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(4, 7);
      end
      if (q.size() == 0) begin
        chk("rand_req_without_op", 1, 0);
      end else begin
        chk("rand_req_addr", dmem_addr, q[0].alu);
        chk("rand_req_we", dmem_we, q[0].mw);
        if (q[0].mw) chk("rand_req_wdata", dmem_wdata, q[0].sd);
      end
      rdy = (waited == lat);
      dmem_ready = rdy;
      if (rdy) dmem_rdata = env_mem[dmem_addr[3:0]];
      #1;
      chk("rand_stall", mem_stall, !(waited == 0 && rdy));
      if (rdy) begin
        if (dmem_we) env_mem[dmem_addr[3:0]] = dmem_wdata;
        in_acc = 1'b0;
      end else if (waited == TO) begin
        front_to    = 1'b1;
        exp_bus_err = 1'b1;
        in_acc      = 1'b0;
      end else begin
        waited++;
      end
    end else begin
      #1;
      chk("rand_idle_stall", mem_stall, 0);
    end
    if (!mem_stall) begin
      if (p_v && !p_f) q.push_back('{p_alu, p_sd, p_rd, p_rw, p_mr, p_mw, p_m2r});
      new_pending();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   nreq;
    tbl[0] = '{1'b1, 1'b0, 16'h1234, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 16'h1234};
    tbl[1] = '{1'b1, 1'b0, 16'hFFFF, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 16'hFFFF};
    tbl[2] = '{1'b1, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 16'hFFFF};
    tbl[3] = '{1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 16'hFFFF};
    tbl[4] = '{1'b1, 1'b0, 16'h8001, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 16'h8001};

    // Reset state
    rst_n = 1'b0; ex_idle(); dmem_ready = 1'b0; dmem_rdata = 16'h0;
    tick(); tick();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_wb_reg_addr", wb_reg_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    rst_n = 1'b1;

    // ALU pass-through / flush / bubble table
    for (int i = 0; i < 5; i++) begin
      ex_set(tbl[i].v, tbl[i].f, tbl[i].alu, 16'h0, tbl[i].rd, tbl[i].rw, 1'b0, 1'b0, 1'b0);
      #1;
      chk("tbl_stall", mem_stall, 0);
      tick();
      chk("tbl_fwd_data", mem_forward_data, tbl[i].alu);
      chk("tbl_fwd_addr", mem_fwd_reg_addr, tbl[i].rd);
      chk("tbl_fwd_rw", mem_fwd_reg_write, tbl[i].e_fwrw);
      chk("tbl_req", dmem_req, 0);
      ex_idle();
      tick();
      chk("tbl_wb_valid", wb_valid, tbl[i].e_wbv);
      chk("tbl_wb_rw", wb_reg_write, tbl[i].e_wbrw);
      chk("tbl_wb_addr", wb_reg_addr, tbl[i].e_wba);
      chk("tbl_wb_data", wb_data, tbl[i].e_wbd);
    end

    // Zero-wait load
    ex_set(1'b1, 1'b0, 16'h0040, 16'h0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    dmem_ready = 1'b1; dmem_rdata = 16'hBEEF;
    tick();
    ex_idle();
    #1;
    chk("zw_req", dmem_req, 1);
    chk("zw_addr", dmem_addr, 16'h0040);
    chk("zw_we", dmem_we, 0);
    chk("zw_stall", mem_stall, 0);
    tick();
    chk("zw_req_drop", dmem_req, 0);
    chk("zw_wb_valid", wb_valid, 1);
    chk("zw_wb_data", wb_data, 16'hBEEF);
    chk("zw_wb_addr", wb_reg_addr, 2);
    chk("zw_wb_rw", wb_reg_write, 1);

    // Wait-state store with a younger instruction held behind it
    dmem_ready = 1'b0;
    ex_set(1'b1, 1'b0, 16'h0010, 16'hA5A5, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    ex_set(1'b1, 1'b0, 16'h7777, 16'h0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      dmem_ready = (k == 2);
      #1;
      chk("ws_req", dmem_req, 1);
      chk("ws_addr", dmem_addr, 16'h0010);
      chk("ws_we", dmem_we, 1);
      chk("ws_wdata", dmem_wdata, 16'hA5A5);
      chk("ws_stall", mem_stall, 1);
      chk("ws_held_fwd", mem_forward_data, 16'h0010);
      tick();
    end
    dmem_ready = 1'b0;
    #1;
    chk("ws_wb_valid", wb_valid, 1);
    chk("ws_wb_rw", wb_reg_write, 0);
    chk("ws_wb_addr", wb_reg_addr, 4);
    chk("ws_no_reissue", dmem_req, 0);
    chk("ws_resume_stall", mem_stall, 0);
    tick();
    chk("ws_young_fwd", mem_forward_data, 16'h7777);
    chk("ws_young_fwd_rw", mem_fwd_reg_write, 1);
    chk("ws_bubble", wb_valid, 0);
    ex_idle();
    tick();
    chk("ws_young_wb_valid", wb_valid, 1);
    chk("ws_young_wb_data", wb_data, 16'h7777);
    chk("ws_young_wb_addr", wb_reg_addr, 6);

    // Timeout: ready never arrives
    ex_set(1'b1, 1'b0, 16'h0022, 16'h0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    ex_idle();
    nreq = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (dmem_req) nreq++;
      else if (nreq > 0) break;
      tick();
    end
    chk("to_req_cycles", nreq, TO + 1);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_rw", wb_reg_write, 0);
    chk("to_bus_error", bus_error, 1);
    chk("to_stall_released", mem_stall, 0);
    tick();
    chk("to_bus_error_sticky", bus_error, 1);
    ex_set(1'b1, 1'b0, 16'h0F0F, 16'h0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    ex_idle();
    tick();
    chk("to_resume_wb_valid", wb_valid, 1);
    chk("to_resume_wb_data", wb_data, 16'h0F0F);
    chk("to_bus_error_still", bus_error, 1);

    // Flush of a younger load while an older load stalls
    ex_set(1'b1, 1'b0, 16'h0030, 16'h0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    ex_set(1'b1, 1'b1, 16'h0031, 16'h0, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      dmem_ready = (k == 1);
      dmem_rdata = (k == 1) ? 16'hC0DE : 16'h0BAD;
      #1;
      tick();
    end
    dmem_ready = 1'b0;
    chk("fl_old_wb_valid", wb_valid, 1);
    chk("fl_old_wb_data", wb_data, 16'hC0DE);
    chk("fl_old_wb_addr", wb_reg_addr, 5);
    tick();
    ex_idle();
    #1;
    chk("fl_no_req", dmem_req, 0);
    chk("fl_fwd_rw", mem_fwd_reg_write, 0);
    tick();
    chk("fl_no_retire", wb_valid, 0);

    // Reset in the middle of a waiting load
    ex_set(1'b1, 1'b0, 16'h0044, 16'h0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    ex_idle();
    tick();
    chk("rm_in_wait_req", dmem_req, 1);
    rst_n = 1'b0;
    tick();
    chk("rm_req", dmem_req, 0);
    chk("rm_stall", mem_stall, 0);
    chk("rm_wb_valid", wb_valid, 0);
    chk("rm_bus_error", bus_error, 0);
    rst_n = 1'b1;
    tick();
    chk("rm_no_retire", wb_valid, 0);

    // Random traffic against the in-order transaction model
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 16'($urandom);
      env_mem[i]   = model_mem[i];
    end
    gen_on = 1'b1; in_acc = 1'b0; front_to = 1'b0; exp_bus_err = 1'b0;
    new_pending();
    for (int c = 0; c < 600; c++) rand_cycle();
    gen_on = 1'b0;
    p_v = 1'b0;
    for (int c = 0; c < 3 * (TO + 3); c++) rand_cycle();
    chk("rand_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
